// File: rtl/seg7_scan_mux_pkg.sv
// Shared constants for the seven-segment scan driver: hex segment patterns and scan FSM states.
package seg7_scan_mux_pkg;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Segment order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    typedef enum logic {
        ST_DWELL = 1'b0,
        ST_BLANK = 1'b1
    } scan_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational 4-bit hex value to seven-segment pattern decoder (0..9, A..F).
module seg7_hex_decode
    import seg7_scan_mux_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        unique case (value)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Multi-digit seven-segment scan driver with shadow/active double buffering and inter-digit blanking.
// Optional leading-zero blanking is enabled by defining SEG7_SCAN_LZB_EN.
module seg7_scan_mux
    import seg7_scan_mux_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DWELL_CYCLES = 10000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_done
);

    localparam int unsigned CNT_MAX = max_u(DWELL_CYCLES, BLANK_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);

    scan_state_t             state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    running_q;
    logic                    wrap, wrap_q;
    logic                    advance;

    logic [4*NUM_DIGITS-1:0] shadow_q, active_q;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, active_dp_q;
    logic                    pending_q;

    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [3:0]              digit_val;
    logic [6:0]              digit_seg;
    logic                    lit;
    logic [6:0]              seg_d;
    logic [NUM_DIGITS-1:0]   dig_en_d;
    logic                    dp_d;

    // running_q holds the scan idle for the first cycle after reset release, so
    // DWELL idx 0 starts counting on that edge and shows one edge later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_DWELL;
            idx_q     <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            running_q <= 1'b1;
            wrap_q    <= wrap;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wrap    = 1'b0;
        advance = 1'b0;
        if (running_q) begin
            cnt_d = cnt_q + 1'b1;
            unique case (state_q)
                ST_DWELL: begin
                    if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
                        cnt_d = '0;
                        if (BLANK_CYCLES == 0) advance = 1'b1;
                        else state_d = ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_DWELL;
                        advance = 1'b1;
                    end
                end
            endcase
            if (advance) begin
                if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                    idx_d = '0;
                    wrap  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        end
    end

    // The wrap copy reads the pre-edge shadow, so a load on the wrap cycle waits a frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            active_q    <= '0;
            active_dp_q <= '0;
            pending_q   <= 1'b0;
        end else begin
            if (wrap && pending_q) begin
                active_q    <= shadow_q;
                active_dp_q <= shadow_dp_q;
            end
            if (load) begin
                shadow_q    <= digits_in;
                shadow_dp_q <= dp_in;
            end
            if (load)      pending_q <= 1'b1;
            else if (wrap) pending_q <= 1'b0;
        end
    end

`ifdef SEG7_SCAN_LZB_EN
    logic leading;

    always_comb begin
        blank_mask = '0;
        leading    = 1'b1;
        for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (leading && active_q[4*i +: 4] == 4'h0) blank_mask[i] = 1'b1;
            else leading = 1'b0;
        end
    end
`else
    always_comb begin
        blank_mask = '0;
    end
`endif

    assign digit_val = active_q[{idx_q, 2'b00} +: 4];

    seg7_hex_decode u_decode (
        .value (digit_val),
        .seg   (digit_seg)
    );

    always_comb begin
        lit      = running_q && (state_q == ST_DWELL);
        seg_d    = SEG_OFF;
        dig_en_d = '0;
        dp_d     = 1'b0;
        if (lit) begin
            dig_en_d = NUM_DIGITS'(1) << idx_q;
            dp_d     = active_dp_q[idx_q];
            if (!blank_mask[idx_q]) seg_d = digit_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_out    <= SEG_OFF;
            dig_en     <= '0;
            dp_out     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            seg_out    <= seg_d;
            dig_en     <= dig_en_d;
            dp_out     <= dp_d;
            frame_done <= wrap_q;
        end
    end

endmodule
